// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// PROGRAM_LOADER_CHECKSUM_EN adds the checksum trailer state.
package loader_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEFAULT_ADDR_W  = 12;
  localparam int unsigned DEFAULT_TIMEOUT = 1000;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StHdr, StLoad, StCsum, StDone} loader_state_e;
`else
  typedef enum logic [1:0] {StHdr, StLoad, StDone} loader_state_e;
`endif

endpackage

// File: rtl/serial_word_deser.sv
// Synchronizes the async strobe/data pair and assembles LSB-first 32-bit words.
// A partial word is dropped after TIMEOUT idle cycles.
module serial_word_deser
  import loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_on_i,
  input  logic              data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_evt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] on_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   on_prev_q;
  logic [WORD_W-1:0]      sr_q;
  logic [4:0]             cnt_q;
  logic [TW-1:0]          idle_q;
  logic                   bit_evt;
  logic                   data_s;

  assign bit_evt    = on_sync_q[SYNC_STAGES-1] & ~on_prev_q;
  assign data_s     = dat_sync_q[SYNC_STAGES-1];
  // Word including the bit arriving this cycle, so word_evt and word align.
  assign word_o     = {data_s, sr_q[WORD_W-1:1]};
  assign word_evt_o = bit_evt && (cnt_q == 5'd31);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      on_sync_q  <= '0;
      dat_sync_q <= '0;
      on_prev_q  <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
    end else begin
      on_sync_q  <= SYNC_STAGES'({on_sync_q, data_on_i});
      dat_sync_q <= SYNC_STAGES'({dat_sync_q, data_i});
      on_prev_q  <= on_sync_q[SYNC_STAGES-1];
      if (bit_evt) begin
        sr_q   <= word_o;
        cnt_q  <= cnt_q + 5'd1;
        idle_q <= '0;
      end else if (cnt_q != 5'd0) begin
        if (idle_q == TW'(TIMEOUT - 1)) begin
          sr_q   <= '0;
          cnt_q  <= '0;
          idle_q <= '0;
        end else begin
          idle_q <= idle_q + TW'(1);
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed word stream into memory while holding the processor in reset.
// PROGRAM_LOADER_CHECKSUM_EN enables the running-sum trailer check.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dataOnPin,
  input  logic              dataPin,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  output logic              proc_reset,
  output logic              done,
  output logic              checksum_ok,
  output logic [ADDR_W-1:0] words_loaded
);

  logic [WORD_W-1:0] word;
  logic              word_evt;

  serial_word_deser #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) u_deser (
    .clk_i     (clk),
    .rst_i     (reset),
    .data_on_i (dataOnPin),
    .data_i    (dataPin),
    .word_o    (word),
    .word_evt_o(word_evt)
  );

  loader_state_e     state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] words_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_data_q;
  logic              done_q;
  logic              proc_reset_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
  logic              csum_ok_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StHdr;
      len_q        <= '0;
      addr_q       <= '0;
      words_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      done_q       <= 1'b0;
      proc_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      csum_ok_q    <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        StHdr: begin
          if (word_evt) begin
            len_q   <= word[ADDR_W-1:0];
            addr_q  <= '0;
            words_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
            if (word[ADDR_W-1:0] == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q      <= StCsum;
`else
              state_q      <= StDone;
              done_q       <= 1'b1;
              proc_reset_q <= 1'b0;
`endif
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (word_evt) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= word;
            addr_q     <= addr_q + ADDR_W'(1);
            words_q    <= words_q + ADDR_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + word;
`endif
            if (words_q + ADDR_W'(1) == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q      <= StCsum;
`else
              state_q      <= StDone;
              done_q       <= 1'b1;
              proc_reset_q <= 1'b0;
`endif
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        StCsum: begin
          if (word_evt) begin
            csum_ok_q    <= (word == sum_q);
            state_q      <= StDone;
            done_q       <= 1'b1;
            proc_reset_q <= 1'b0;
          end
        end
`endif
        StDone: begin
          if (rearm) begin
            state_q      <= StHdr;
            done_q       <= 1'b0;
            proc_reset_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_ok_q    <= 1'b0;
`endif
          end
        end
        default: state_q <= StHdr;
      endcase
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign done         = done_q;
  assign proc_reset   = proc_reset_q;
  assign words_loaded = words_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign checksum_ok  = csum_ok_q;
`else
  assign checksum_ok  = 1'b1;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed bench for program_loader against a queue-based write model.
// Checksum expectations follow PROGRAM_LOADER_CHECKSUM_EN.
module tb_program_loader;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              dataOnPin = 1'b0;
  logic              dataPin = 1'b0;
  logic              rearm = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              proc_reset;
  logic              done;
  logic              checksum_ok;
  logic [ADDR_W-1:0] words_loaded;

  program_loader #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dataOnPin   (dataOnPin),
    .dataPin     (dataPin),
    .rearm       (rearm),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .proc_reset  (proc_reset),
    .done        (done),
    .checksum_ok (checksum_ok),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t         act_q[$];
  logic [31:0] pay[$];
  int          total = 0;
  int          bad = 0;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic IDLE_CSUM = 1'b0;
`else
  localparam logic IDLE_CSUM = 1'b1;
`endif

  always @(negedge clk) if (mem_we === 1'b1) act_q.push_back('{a: mem_addr, d: mem_data});

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) dataPin = b;
    repeat (2) @(negedge clk);
    dataOnPin = 1'b1;
    repeat (3) @(negedge clk);
    dataOnPin = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) send_bit(w[i]);
  endtask

  task automatic pulse_rearm(input string tag);
    @(negedge clk) rearm = 1'b1;
    @(negedge clk) rearm = 1'b0;
    chk({tag, "_proc_reset"}, 32'(proc_reset), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Header n, payload pay[0..n-1], optional trailer; rearm pulsed just before pay[rearm_at].
  task automatic run_load(input string tag, input int n, input bit bad_trailer,
                          input int rearm_at);
    logic [31:0] sum;
    int          waited;
    act_q.delete();
    sum = 32'd0;
    send_word(32'(n));
    for (int i = 0; i < n; i++) begin
      if (i == rearm_at) begin
        pulse_rearm({tag, "_rearm_load"});
        chk({tag, "_rearm_ignored"}, 32'(checksum_ok), 32'(IDLE_CSUM));
      end
      send_word(pay[i]);
      sum = sum + pay[i];
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_word(bad_trailer ? 32'd0 : sum);
`endif
    waited = 0;
    while (done !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_nwr"}, 32'(act_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < act_q.size()) begin
        chk({tag, "_addr"}, 32'(act_q[i].a), 32'(ADDR_W'(i)));
        chk({tag, "_data"}, act_q[i].d, pay[i]);
      end
    end
    chk({tag, "_words"}, 32'(words_loaded), 32'(n));
    chk({tag, "_proc_reset"}, 32'(proc_reset), 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk({tag, "_csum"}, 32'(checksum_ok), bad_trailer ? 32'd0 : 32'd1);
`else
    chk({tag, "_csum"}, 32'(checksum_ok), 32'd1);
`endif
  endtask

  initial begin
    int pre_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_proc_reset", 32'(proc_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_csum", 32'(checksum_ok), 32'(IDLE_CSUM));

    pay = '{32'hDEADBEEF, 32'h00000001, 32'h80000000};
    run_load("load3", 3, 1'b0, -1);
    chk("done_no_we", 32'(mem_we), 32'd0);
    pulse_rearm("rearm1");
    chk("rearm1_csum", 32'(checksum_ok), 32'(IDLE_CSUM));
    run_load("load3_badtrl", 3, 1'b1, -1);

    // Stray bits must be flushed by the idle timeout.
    pulse_rearm("rearm2");
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    repeat (TIMEOUT + 5) @(negedge clk);
    pay = '{$urandom};
    run_load("timeout", 1, 1'b0, -1);

    pulse_rearm("rearm3");
    act_q.delete();
    send_word(32'd4);
    send_word(32'h11111111);
    send_word(32'h22222222);
    repeat (4) @(negedge clk);
    pre_cnt = act_q.size();
    chk("midrst_prewr", 32'(pre_cnt), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_proc_reset", 32'(proc_reset), 32'd1);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_nowr", 32'(act_q.size()), 32'(pre_cnt));
    pay = '{32'hCAFEF00D};
    run_load("midrst_reload", 1, 1'b0, -1);

    pulse_rearm("rearm4");
    pay.delete();
    run_load("hdr0", 0, 1'b0, -1);

    pulse_rearm("rearm5");
    pay = '{$urandom, $urandom};
    run_load("rearm_in_load", 2, 1'b0, 1);

    for (int k = 0; k < 5; k++) begin
      int n;
      pulse_rearm("rearm_rand");
      n = int'($urandom_range(1, 6));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back($urandom);
      run_load("rand", n, 1'($urandom_range(0, 1)) && (k != 0), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
